// File: rtl/sifh_peak_finder_pkg.sv
// rtl/sifh_peak_finder_pkg.sv - shared SiFH widths, peak-finder FSM states and window-bound helpers
// Macro defaults apply only when the shared parametersSiFH.vh has not been read ahead of this file.
`ifndef Nb
`define Nb 4
`endif
`ifndef peakMax
`define peakMax 8
`endif
`ifndef RAM_ADDR
`define RAM_ADDR 5
`endif
`ifndef BIN_NUM_PER_HIS
`define BIN_NUM_PER_HIS 16
`endif
`ifndef PIXEL_NUM_PER_RAM
`define PIXEL_NUM_PER_RAM 2
`endif

package sifh_peak_finder_pkg;
  localparam int NB     = `Nb;
  localparam int PEAK_W = `peakMax;
  localparam int ADDR_W = `RAM_ADDR;
  localparam int BINS   = `BIN_NUM_PER_HIS;
  localparam int PIXELS = `PIXEL_NUM_PER_RAM;
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, REPORT, DONE} state_t;

  // Bounds are computed one bit wider than a bin index so neither side can wrap.
  function automatic logic [NB-1:0] winLow(input logic [NB-1:0] bin, input logic [NB:0] win);
    logic [NB:0] wide;
    wide = {1'b0, bin};
    return (wide < win) ? '0 : NB'(wide - win);
  endfunction

  function automatic logic [NB-1:0] winHigh(input logic [NB-1:0] bin, input logic [NB:0] win);
    logic [NB:0] wide;
    wide = {1'b0, bin} + win;
    return (wide > (NB+1)'(BINS - 1)) ? NB'(BINS - 1) : NB'(wide);
  endfunction
endpackage

// File: rtl/sifh_max_tracker.sv
// rtl/sifh_max_tracker.sv - running per-pixel histogram maximum; ties keep the lowest bin
module sifh_max_tracker
  import sifh_peak_finder_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              clear,
  input  logic              valid,
  input  logic [PEAK_W-1:0] count,
  input  logic [NB-1:0]     bin,
  output logic [PEAK_W-1:0] maxCount,
  output logic [NB-1:0]     maxBin
);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      maxCount <= '0;
      maxBin   <= '0;
    end else if (clear) begin
      maxCount <= '0;
      maxBin   <= '0;
    end else if (valid && (count > maxCount)) begin
      maxCount <= count;
      maxBin   <= bin;
    end
  end

endmodule

// File: rtl/sifh_peak_finder.sv
// rtl/sifh_peak_finder.sv - scans every pixel's histogram over SRAM port b and reports its peak
// plus the TH-/TH+ window used by the second histogramming pass.
module sifh_peak_finder
  import sifh_peak_finder_pkg::*;
#(
  parameter int WIN       = 4,
  parameter int MIN_COUNT = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [PEAK_W-1:0] counts,
  output logic [ADDR_W-1:0] raddr,
  output logic              rEnable,
  output logic              readFlag,
  output logic              busy,
  output logic              peakValid,
  output logic [PIX_W-1:0]  peakPixel,
  output logic [NB-1:0]     peakBin,
  output logic [PEAK_W-1:0] peakCount,
  output logic [NB-1:0]     thLow,
  output logic [NB-1:0]     thHigh,
  output logic              noPeak,
  output logic              done
);

  localparam logic [NB-1:0]     LAST_BIN = NB'(BINS - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(PIXELS - 1);
  localparam logic [NB:0]       WIN_V    = (NB+1)'(WIN);
  localparam logic [PEAK_W-1:0] MIN_V    = PEAK_W'(MIN_COUNT);

  state_t            state;
  logic [PIX_W-1:0]  pixel;
  logic [NB-1:0]     bin;
  logic              clearMax;
  logic              rdValid;
  logic [NB-1:0]     rdBin;
  logic [PEAK_W-1:0] maxCount;
  logic [NB-1:0]     maxBin;
  logic              lowPeak;

  assign raddr   = ADDR_W'({pixel, bin});
  assign lowPeak = (maxCount < MIN_V);

  // rdValid/rdBin follow the issued address by one cycle to line up with the SRAM read data.
  sifh_max_tracker u_tracker (
    .clk      (clk),
    .res      (res),
    .clear    (clearMax),
    .valid    (rdValid),
    .count    (counts),
    .bin      (rdBin),
    .maxCount (maxCount),
    .maxBin   (maxBin)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      pixel     <= '0;
      bin       <= '0;
      rEnable   <= 1'b1;
      readFlag  <= 1'b0;
      busy      <= 1'b0;
      peakValid <= 1'b0;
      peakPixel <= '0;
      peakBin   <= '0;
      peakCount <= '0;
      thLow     <= '0;
      thHigh    <= '0;
      noPeak    <= 1'b0;
      done      <= 1'b0;
      clearMax  <= 1'b0;
      rdValid   <= 1'b0;
      rdBin     <= '0;
    end else begin
      peakValid <= 1'b0;
      done      <= 1'b0;
      clearMax  <= 1'b0;
      rdValid   <= readFlag & ~rEnable;
      rdBin     <= bin;
      case (state)
        IDLE: begin
          // The done cycle is spent in IDLE with busy still high, so a start there is dropped.
          if (start && !done) begin
            state    <= SCAN;
            pixel    <= '0;
            bin      <= '0;
            readFlag <= 1'b1;
            rEnable  <= 1'b0;
            busy     <= 1'b1;
            clearMax <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        SCAN: begin
          if (bin == LAST_BIN) begin
            state    <= DRAIN;
            readFlag <= 1'b0;
            rEnable  <= 1'b1;
          end else begin
            bin <= bin + 1'b1;
          end
        end
        DRAIN: state <= REPORT;
        REPORT: begin
          peakValid <= 1'b1;
          peakPixel <= pixel;
          peakBin   <= maxBin;
          peakCount <= maxCount;
          noPeak    <= lowPeak;
          thLow     <= lowPeak ? '0 : winLow(maxBin, WIN_V);
          thHigh    <= lowPeak ? LAST_BIN : winHigh(maxBin, WIN_V);
          if (pixel == LAST_PIX) begin
            state <= DONE;
          end else begin
            state    <= SCAN;
            pixel    <= pixel + 1'b1;
            bin      <= '0;
            readFlag <= 1'b1;
            rEnable  <= 1'b0;
            clearMax <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sifh_peak_finder.md
SIFH_PEAK_FINDER -- requirements
Module: sifh_peak_finder

Interface
REQ-001 Parameter WIN, default 4: half-width in bins of the second-pass window around the peak.
REQ-002 Parameter MIN_COUNT, default 2: minimum peak count for a valid peak.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 res  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a scan of all pixels; sampled only in IDLE.
REQ-006 counts  input  `peakMax  SRAM port-b read data, valid one cycle after its address.
REQ-007 raddr  output  `RAM_ADDR  SRAM port-b address, {pixel, bin}.
REQ-008 rEnable  output  1  SRAM port-b read enable, 0 = enabled.
REQ-009 readFlag  output  1  SRAM port-b memory enable, 1 = enabled.
REQ-010 busy  output  1  high from the first SCAN cycle through DONE.
REQ-011 peakValid  output  1  one-cycle strobe qualifying the per-pixel result outputs.
REQ-012 peakPixel  output  PIX_W = log2(`PIXEL_NUM_PER_RAM)  pixel index of the result.
REQ-013 peakBin / peakCount  output  `Nb / `peakMax  bin index of the maximum and its count.
REQ-014 thLow / thHigh  output  `Nb each  window bounds (TH-/TH+) for second-pass histogramming.
REQ-015 noPeak  output  1  peakCount < MIN_COUNT for this pixel.
REQ-016 done  output  1  one-cycle pulse after the last pixel's result.

Function
REQ-017 States SHALL be IDLE, SCAN, DRAIN, REPORT, DONE: IDLE->SCAN on start; SCAN->DRAIN after bin `BIN_NUM_PER_HIS-1 is addressed; DRAIN->REPORT; REPORT->SCAN for the next pixel, or ->DONE after the last pixel; DONE->IDLE.
REQ-018 SCAN SHALL issue one read per cycle with readFlag=1 and rEnable=0, bin 0 to `BIN_NUM_PER_HIS-1; all other states SHALL drive readFlag=0 and rEnable=1.
REQ-019 The maximum SHALL update only on a strictly greater count, so ties keep the lowest bin; the maximum SHALL clear to count 0, bin 0 at the start of each pixel.
REQ-020 The pixel period SHALL be `BIN_NUM_PER_HIS+2 cycles; peakValid for pixel 0 SHALL assert `BIN_NUM_PER_HIS+2 edges after the edge that samples start.
REQ-021 Window bounds: thLow = peakBin-WIN clamped at 0; thHigh = peakBin+WIN clamped at `BIN_NUM_PER_HIS-1; arithmetic SHALL be `Nb+1 bits wide with no wrap.
REQ-022 If noPeak=1, thLow SHALL be 0 and thHigh SHALL be `BIN_NUM_PER_HIS-1 (full range).
REQ-023 Result outputs SHALL hold their values until the next peakValid.
REQ-024 done SHALL assert one cycle after the last pixel's peakValid; busy SHALL drop in the cycle after done.
REQ-025 start outside IDLE SHALL be ignored, including a start coincident with done.
REQ-026 A count equal to the all-ones saturated value SHALL be compared normally, with no overflow.

Reset
REQ-027 On res low, state SHALL become IDLE, all outputs 0 except rEnable=1, and the max tracker and pixel counter SHALL clear, regardless of scan progress.
REQ-028 After res is released, the block SHALL wait in IDLE for a new start; no partial result SHALL be emitted.

Structure
REQ-029 `Nb, `peakMax, `RAM_ADDR, `BIN_NUM_PER_HIS and `PIXEL_NUM_PER_RAM SHALL come from the shared parametersSiFH.vh; WIN and MIN_COUNT remain local parameters.
REQ-030 The compare/capture datapath SHALL be a sub-module sifh_max_tracker (clear, valid, count, bin in; maxCount, maxBin out); the FSM and address generation stay in the top.

Verification (`BIN_NUM_PER_HIS=16, 2 pixels, WIN=4, MIN_COUNT=2)
REQ-031 Pixel 0 has a single peak of 9 at bin 7 -> peakBin=7, peakCount=9, thLow=3, thHigh=11, noPeak=0; peakValid 18 edges after start.
REQ-032 Peak of 5 at bin 1 and peak of 6 at bin 15 -> thLow=0 for the first, thHigh=15 for the second.
REQ-033 Count 5 at bins 3 and 10 -> peakBin=3.
REQ-034 All-zero histogram -> peakCount=0, noPeak=1, thLow=0, thHigh=15.
REQ-035 start pulsed again mid-scan, then res low at pixel 1 bin 8 -> second start ignored; all outputs reset; a later start re-scans from raddr 0.
